timer_entry: RTL

Keypad-to-timer front end for the microwave timer chain. Accepts debounced key codes from the keypad encoder, shifts digits into a four-digit MM:SS entry buffer, and on START drives the preset values and an active-low load strobe into the down-counting digit stages (mod-10/mod-6). It then runs the cook-cycle state machine, gating the counters' enable and handling door-open pause, cancel, and end-of-count.

---
 rtl/timer_entry.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/timer_entry.sv
// timer_entry: keypad front end and cook-cycle sequencer for the microwave timer.
// Shifts digit keys into an MM:SS entry buffer, presents it as preset values to
// the down-counting digit stages, and gates their enable through LOAD/RUN/PAUSE.
//
// Ports
//   clk        in   system clock, rising edge
//   Cn         in   synchronous active-low reset
//   key_valid  in   high while a key is held (rising edge = one key event)
//   key_code   in   0-9 digit, 10 START, 11 CLEAR, 12-15 ignored
//   door_open  in   high while the door is open
//   timer_zero in   all counter digits at zero
//   sec_u/sec_t/min_u/min_t out  BCD preset digits
//   load_n     out  active-low load strobe to the counters
//   clr_n      out  active-low clear strobe to the counters
//   count_en   out  enable into the least-significant counter digit
//   done       out  one-cycle pulse at natural end of count
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | accepting digits, CLEAR and START
// ST_LOAD  | one cycle with load_n low, counters take the presets
// ST_RUN   | counting; exits on zero, CLEAR or door open
// ST_PAUSE | door opened mid-run; counters hold until START or CLEAR
module timer_entry (
  input  logic       clk,
  input  logic       Cn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       door_open,
  input  logic       timer_zero,
  output logic [3:0] sec_u,
  output logic [3:0] sec_t,
  output logic [3:0] min_u,
  output logic [3:0] min_t,
  output logic       load_n,
  output logic       clr_n,
  output logic       count_en,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  localparam logic [3:0] KEY_START = 4'd10;
  localparam logic [3:0] KEY_CLEAR = 4'd11;

  state_t     state_q, state_d;
  logic [3:0] sec_u_q, sec_u_d;
  logic [3:0] sec_t_q, sec_t_d;
  logic [3:0] min_u_q, min_u_d;
  logic [3:0] min_t_q, min_t_d;
  logic       load_n_q, load_n_d;
  logic       clr_n_q, clr_n_d;
  logic       count_en_q, count_en_d;
  logic       done_q, done_d;
  logic       key_prev_q;

  logic kev;
  logic key_digit;
  logic key_start;
  logic key_clear;
  logic all_zero;

  // One action per press: only the rising edge of key_valid counts.
  assign kev       = key_valid & ~key_prev_q;
  assign key_digit = kev & (key_code <= 4'd9);
  assign key_start = kev & (key_code == KEY_START);
  assign key_clear = kev & (key_code == KEY_CLEAR);
  assign all_zero  = (sec_u_q == 4'd0) && (sec_t_q == 4'd0) &&
                     (min_u_q == 4'd0) && (min_t_q == 4'd0);

  always_comb begin
    state_d  = state_q;
    sec_u_d  = sec_u_q;
    sec_t_d  = sec_t_q;
    min_u_d  = min_u_q;
    min_t_d  = min_t_q;
    load_n_d = 1'b1;
    clr_n_d  = 1'b1;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_digit) begin
          min_t_d = min_u_q;
          min_u_d = sec_t_q;
          sec_t_d = sec_u_q;
          sec_u_d = key_code;
        end else if (key_clear) begin
          sec_u_d = 4'd0;
          sec_t_d = 4'd0;
          min_u_d = 4'd0;
          min_t_d = 4'd0;
          clr_n_d = 1'b0;
        end else if (key_start && !door_open && !all_zero) begin
          // The tens-of-seconds counter is mod-6, so anything above 5 is clamped.
          if (sec_t_q > 4'd5) begin
            sec_t_d = 4'd5;
          end
          load_n_d = 1'b0;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // A key event losing to a higher-priority exit is simply dropped.
        if (timer_zero) begin
          done_d  = 1'b1;
          sec_u_d = 4'd0;
          sec_t_d = 4'd0;
          min_u_d = 4'd0;
          min_t_d = 4'd0;
          state_d = ST_IDLE;
        end else if (key_clear) begin
          clr_n_d = 1'b0;
          sec_u_d = 4'd0;
          sec_t_d = 4'd0;
          min_u_d = 4'd0;
          min_t_d = 4'd0;
          state_d = ST_IDLE;
        end else if (door_open) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (key_clear) begin
          clr_n_d = 1'b0;
          sec_u_d = 4'd0;
          sec_t_d = 4'd0;
          min_u_d = 4'd0;
          min_t_d = 4'd0;
          state_d = ST_IDLE;
        end else if (key_start && !door_open) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Enable is registered alongside the state so it is high exactly while in RUN.
    count_en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!Cn) begin
      state_q    <= ST_IDLE;
      sec_u_q    <= 4'd0;
      sec_t_q    <= 4'd0;
      min_u_q    <= 4'd0;
      min_t_q    <= 4'd0;
      load_n_q   <= 1'b1;
      clr_n_q    <= 1'b0;  // held low through reset so the counters clear too
      count_en_q <= 1'b0;
      done_q     <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_u_q    <= sec_u_d;
      sec_t_q    <= sec_t_d;
      min_u_q    <= min_u_d;
      min_t_q    <= min_t_d;
      load_n_q   <= load_n_d;
      clr_n_q    <= clr_n_d;
      count_en_q <= count_en_d;
      done_q     <= done_d;
      key_prev_q <= key_valid;
    end
  end

  assign sec_u    = sec_u_q;
  assign sec_t    = sec_t_q;
  assign min_u    = min_u_q;
  assign min_t    = min_t_q;
  assign load_n   = load_n_q;
  assign clr_n    = clr_n_q;
  assign count_en = count_en_q;
  assign done     = done_q;

endmodule
